and_unit_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one bitwise-AND datapath (and_pair_unit) between N_REQ requesters.

---
 rtl/and_unit_arbiter_pkg.sv | 19 +
 rtl/and_unit_arbiter_and_pair_unit.sv | 18 +
 rtl/and_unit_arbiter_rr_grant.sv | 46 ++++
 rtl/and_unit_arbiter.sv | 121 ++++++++++++
 tb/tb_and_unit_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/and_unit_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : and_arb_pkg
// Brief   : Shared types and default sizing for the AND-unit arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package and_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam int N_REQ_DEF = 4;
    localparam int DW_DEF    = 8;

endpackage : and_arb_pkg
`default_nettype wire

// File: rtl/and_unit_arbiter_and_pair_unit.sv
`default_nettype none
// ============================================================================
// Module  : and_pair_unit
// Brief   : Shared combinational bitwise-AND datapath.
// Revision: 1.0 - initial release
// ============================================================================
module and_pair_unit #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] y_o
);

    assign y_o = a_i & b_i;

endmodule : and_pair_unit
`default_nettype wire

// File: rtl/and_unit_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
// Module  : rr_grant
// Brief   : Combinational round-robin grant starting the search at ptr_i.
// Revision: 1.0 - initial release
// ============================================================================
module rr_grant #(
    parameter  int N_REQ = 4,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic [N_REQ-1:0] gnt_onehot_o,
    output logic [IDW-1:0]   gnt_id_o,
    output logic             any_o
);

    localparam logic [2*N_REQ-1:0] C_ONE = {{(2*N_REQ-1){1'b0}}, 1'b1};

    logic [2*N_REQ-1:0] w_dbl;
    logic [2*N_REQ-1:0] w_mask;
    logic [2*N_REQ-1:0] w_masked;
    logic [2*N_REQ-1:0] w_iso;

    // Upper copy of the request vector supplies the wrapped-around candidates.
    always_comb begin
        w_dbl        = {req_i, req_i};
        w_mask       = ~((C_ONE << ptr_i) - C_ONE);
        w_masked     = w_dbl & w_mask;
        w_iso        = w_masked & (~w_masked + C_ONE);
        gnt_onehot_o = w_iso[N_REQ-1:0] | w_iso[2*N_REQ-1:N_REQ];
    end

    always_comb begin
        gnt_id_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_onehot_o[i]) begin
                gnt_id_o = gnt_id_o | IDW'(i);
            end
        end
    end

    assign any_o = |req_i;

endmodule : rr_grant
`default_nettype wire

// File: rtl/and_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : and_unit_arbiter
// Brief   : Round-robin sequencer sharing one AND datapath among N_REQ ports.
// Revision: 1.0 - initial release
// ============================================================================
module and_unit_arbiter
    import and_arb_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    parameter  int DW    = DW_DEF,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_a,
    input  logic [N_REQ*DW-1:0] req_b,
    output logic [N_REQ-1:0]    req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DW-1:0]       rsp_data,
    output logic [IDW-1:0]      rsp_id
);

    arb_state_t       state_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   rr_ptr_d;
    logic [DW-1:0]    a_q;
    logic [DW-1:0]    b_q;
    logic [IDW-1:0]   id_q;
    logic             rsp_valid_q;
    logic [DW-1:0]    rsp_data_q;
    logic [IDW-1:0]   rsp_id_q;

    logic [N_REQ-1:0] w_gnt;
    logic [IDW-1:0]   w_gnt_id;
    logic             w_any;
    logic [DW-1:0]    w_sel_a;
    logic [DW-1:0]    w_sel_b;
    logic [DW-1:0]    w_and;

    rr_grant #(
        .N_REQ (N_REQ)
    ) u_rr_grant (
        .req_i        (req_valid),
        .ptr_i        (rr_ptr_q),
        .gnt_onehot_o (w_gnt),
        .gnt_id_o     (w_gnt_id),
        .any_o        (w_any)
    );

    // One-hot AND-OR mux: non-granted operands cannot leak through.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_a = w_sel_a | req_a[i*DW +: DW];
                w_sel_b = w_sel_b | req_b[i*DW +: DW];
            end
        end
    end

    and_pair_unit #(
        .DW (DW)
    ) u_and_pair_unit (
        .a_i (a_q),
        .b_i (b_q),
        .y_o (w_and)
    );

    assign rr_ptr_d  = (rsp_id_q == IDW'(N_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
    assign req_ready = (state_q == ST_IDLE) ? w_gnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_any) begin
                        a_q     <= w_sel_a;
                        b_q     <= w_sel_b;
                        id_q    <= w_gnt_id;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_data_q  <= w_and;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rr_ptr_q    <= rr_ptr_d;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule : and_unit_arbiter
`default_nettype wire

// File: tb/tb_and_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_and_unit_arbiter
// Brief   : Directed self-checking bench for and_unit_arbiter (N_REQ=4 and 3).
// Revision: 1.0 - initial release
// ============================================================================
module tb_and_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  req_valid = '0;
    logic [31:0] req_a = {8'hFF, 8'hAA, 8'h3C, 8'hF0};
    logic [31:0] req_b = {8'h81, 8'h5F, 8'h0F, 8'h3C};
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;

    logic [2:0]  r3_valid = '0;
    logic [23:0] r3_a = {8'hAA, 8'h3C, 8'hF0};
    logic [23:0] r3_b = {8'h5F, 8'h0F, 8'h3C};
    logic [2:0]  r3_ready;
    logic        r3_rsp_valid;
    logic        r3_rsp_ready = 1'b0;
    logic [7:0]  r3_rsp_data;
    logic [1:0]  r3_rsp_id;

    int n_tests = 0;
    int n_fail  = 0;

    // a & b per requester of the 4-port instance
    logic [7:0] exp_and [4] = '{8'h30, 8'h0C, 8'h0A, 8'h81};

    always #5 clk = ~clk;

    and_unit_arbiter #(.N_REQ(4), .DW(8)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    and_unit_arbiter #(.N_REQ(3), .DW(8)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (r3_valid),
        .req_a     (r3_a),
        .req_b     (r3_b),
        .req_ready (r3_ready),
        .rsp_valid (r3_rsp_valid),
        .rsp_ready (r3_rsp_ready),
        .rsp_data  (r3_rsp_data),
        .rsp_id    (r3_rsp_id)
    );

    // Protocol monitor and scoreboard for the 4-port instance
    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q [$];
    exp_t       sb_e;
    logic       hold_prev = 1'b0;
    logic [7:0] prev_data = '0;
    logic [1:0] prev_id   = '0;

    always @(negedge clk) begin
        #2;
        if (rst) begin
            sb_q.delete();
            hold_prev = 1'b0;
        end else begin
            n_tests++;
            if (!$onehot0(req_ready)) begin
                n_fail++;
                $display("FAIL onehot0: req_ready=%b required at most one bit", req_ready);
            end
            n_tests++;
            if (rsp_valid && (req_ready != 4'b0000)) begin
                n_fail++;
                $display("FAIL ready_outside_idle: req_ready=%b required 0000", req_ready);
            end
            if (hold_prev) begin
                n_tests++;
                if (!rsp_valid || rsp_data !== prev_data || rsp_id !== prev_id) begin
                    n_fail++;
                    $display("FAIL rsp_stable: valid=%b data=%h id=%0d required 1/%h/%0d",
                             rsp_valid, rsp_data, rsp_id, prev_data, prev_id);
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_q.push_back('{id: 2'(i), data: exp_and[i]});
                end
            end
            if (rsp_valid && rsp_ready) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard: response id=%0d data=%h required no response",
                             rsp_id, rsp_data);
                end else begin
                    sb_e = sb_q.pop_front();
                    if (rsp_id !== sb_e.id || rsp_data !== sb_e.data) begin
                        n_fail++;
                        $display("FAIL scoreboard: id=%0d data=%h required id=%0d data=%h",
                                 rsp_id, rsp_data, sb_e.id, sb_e.data);
                    end
                end
            end
            hold_prev = rsp_valid && !rsp_ready;
            prev_data = rsp_data;
            prev_id   = rsp_id;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        req_valid    = '0;
        rsp_ready    = 1'b0;
        r3_valid     = '0;
        r3_rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_rsp: valid=%b data=%h id=%0d required 0/00/0", rsp_valid, rsp_data, rsp_id);
        end
        n_tests++;
        if (req_ready !== 4'b0000 || r3_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: req_ready=%b r3_rsp_valid=%b required 0000/0", req_ready, r3_rsp_valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_grant: req_ready=%b required 0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_t1: rsp_valid=%b required 0", rsp_valid);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h30 || rsp_id !== 2'd0) begin
            n_fail++;
            $display("FAIL single_rsp: valid=%b data=%h id=%0d required 1/30/0", rsp_valid, rsp_data, rsp_id);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_t3: rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id;
        do_reset();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_id = 2'(k % 4);
            #1;
            n_tests++;
            if (req_ready !== (4'b0001 << exp_id)) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: req_ready=%b required %b", k, req_ready, 4'b0001 << exp_id);
            end
            @(negedge clk);
            @(negedge clk);
            #1;
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_data !== exp_and[exp_id]) begin
                n_fail++;
                $display("FAIL rr_rsp[%0d]: valid=%b id=%0d data=%h required 1/%0d/%h",
                         k, rsp_valid, rsp_id, rsp_data, exp_id, exp_and[exp_id]);
            end
            @(negedge clk);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_back_pressure();
        do_reset();
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        n_tests++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_grant: req_ready=%b required 0100", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b1111;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h0A || rsp_id !== 2'd2 || req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h id=%0d ready=%b required 1/0A/2/0000",
                         k, rsp_valid, rsp_data, rsp_id, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL bp_resume: valid=%b req_ready=%b required 0/1000", rsp_valid, req_ready);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_wrap_n3();
        do_reset();
        r3_valid     = 3'b100;
        r3_rsp_ready = 1'b1;
        #1;
        n_tests++;
        if (r3_ready !== 3'b100) begin
            n_fail++;
            $display("FAIL n3_grant2: req_ready=%b required 100", r3_ready);
        end
        @(negedge clk);
        r3_valid = 3'b000;
        @(negedge clk);
        #1;
        n_tests++;
        if (r3_rsp_valid !== 1'b1 || r3_rsp_id !== 2'd2 || r3_rsp_data !== 8'h0A) begin
            n_fail++;
            $display("FAIL n3_rsp2: valid=%b id=%0d data=%h required 1/2/0A", r3_rsp_valid, r3_rsp_id, r3_rsp_data);
        end
        @(negedge clk);
        r3_valid = 3'b101;
        #1;
        n_tests++;
        if (r3_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL n3_wrap: req_ready=%b required 001", r3_ready);
        end
        @(negedge clk);
        r3_valid = 3'b000;
        @(negedge clk);
        #1;
        n_tests++;
        if (r3_rsp_valid !== 1'b1 || r3_rsp_id !== 2'd0 || r3_rsp_data !== 8'h30) begin
            n_fail++;
            $display("FAIL n3_rsp0: valid=%b id=%0d data=%h required 1/0/30", r3_rsp_valid, r3_rsp_id, r3_rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        #1;
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h0C || rsp_id !== 2'd1) begin
            n_fail++;
            $display("FAIL rmo_first: valid=%b data=%h id=%0d required 1/0C/1", rsp_valid, rsp_data, rsp_id);
        end
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        n_tests++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL rmo_grant: req_ready=%b required 0100", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        rst       = 1'b1;
        @(negedge clk);
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 2'd0) begin
            n_fail++;
            $display("FAIL rmo_cleared: valid=%b data=%h id=%0d required 0/00/0", rsp_valid, rsp_data, rsp_id);
        end
        rst       = 1'b0;
        req_valid = 4'b1111;
        #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rmo_ptr: req_ready=%b required 0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        #1;
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'h30) begin
            n_fail++;
            $display("FAIL rmo_after: valid=%b id=%0d data=%h required 1/0/30", rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_wrap_n3();
        test_reset_mid_op();
        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_and_unit_arbiter
`default_nettype wire
